led_pulse_stretcher: RTL and testbench
======================================

// Module: led_pulse_stretcher
// PURPOSE
//   Multi-channel LED one-shot driver: a rising edge on trig[i] lights led[i]
//   for a fixed number of clk cycles, followed by an optional lockout gap.
//   Parametrised in channel count, hold time, gap time and retrigger mode.
//   Sits between panel/event logic and the board LED pins.
// PARAMETERS
//   NUM_CH      4    number of independent channels
//   CNT_W       11   per-channel counter width (bits)
//   HOLD_CYCLES 500  cycles led[i] stays lit per trigger (1 .. 2**CNT_W-1)
//   GAP_CYCLES  0    lockout cycles after hold expiry; 0 = no lockout
//   RETRIG      1    1: edge while lit restarts hold; 0: edge while lit ignored
//   BLINK_HALF  25   half-period in cycles of blink mode (only with LED_BLINK_EN)
// PORTS
//   clk    in   1       system clock, all logic on posedge
//   rst    in   1       asynchronous reset, active-high
//   trig   in   NUM_CH  per-channel trigger level; rising edge = event
//   led    out  NUM_CH  per-channel LED drive, registered
//   busy   out  NUM_CH  1 while channel is in ON or GAP
//   done   out  NUM_CH  1-cycle pulse on the cycle the channel leaves ON
// BEHAVIOUR
//   Reset: led=0, busy=0, done=0, all counters=0, all FSMs=IDLE, trig history=0
//     (a trig held high across reset release counts as one rising edge).
//   Edge detect: edge[i] = trig[i] & ~trig_q[i]; trig_q registered every cycle.
//   Per-channel FSM: IDLE -> ON -> (GAP) -> IDLE.
//   IDLE: edge -> ON, cnt=0; led=1 from the next cycle.
//   ON: cnt increments each cycle; led high exactly HOLD_CYCLES cycles.
//     cnt==HOLD_CYCLES-1 and no restarting edge -> done=1 for one cycle,
//     led=0, go GAP (cnt=0) if GAP_CYCLES>0, else IDLE.
//     Edge in ON, RETRIG=1: cnt=0, stay ON, no done (also on the expiry cycle).
//     Edge in ON, RETRIG=0: ignored.
//   GAP: led=0, busy=1; after GAP_CYCLES cycles -> IDLE; edges ignored.
//   done and busy are registered, aligned with the led transition.
//   Channels are fully independent; simultaneous edges are all served.
//   Counter never wraps: terminal compare stops it; CNT_W must hold
//     max(HOLD_CYCLES, GAP_CYCLES, BLINK_HALF) - 1.
//   Reset asserted mid-operation: immediate return to reset values.
// CONFIGURATION
//   LED_BLINK_EN defined: while ON, led toggles every BLINK_HALF cycles,
//     starting high; a separate blink phase counter is cleared on entry to ON
//     and on every retrigger; led forced 0 outside ON. Hold/done/busy timing unchanged.
//   LED_BLINK_EN undefined: led steady high for the whole ON period;
//     BLINK_HALF unused, no blink counter synthesised.
// STRUCTURE
//   Package led_pkg: state enum (ST_IDLE, ST_ON, ST_GAP), 2-bit state type,
//     shared default constants for hold/gap cycle counts.
//   Sub-module led_oneshot_ch: one channel (edge detect, FSM, counter, blink);
//     top instantiates NUM_CH copies in a generate loop and concatenates outputs.
// TESTING (bench: NUM_CH=4, HOLD_CYCLES=5, GAP_CYCLES=3, BLINK_HALF=2)
//   Single pulse trig[0] at cycle 10 -> led[0] high cycles 11..15, done[0]=1
//     at cycle 15, busy[0] high 11..18, other channels idle.
//   RETRIG=1, second edge at cycle 13 -> led[0] high 11..18, single done at 18.
//   RETRIG=0, second edge at cycle 13 -> ignored; led[0] high 11..15 only.
//   Edge during GAP (cycle 17) -> ignored; edge at cycle 20 -> new hold 21..25.
//   rst asserted at cycle 13 with led[0]=1 -> led/busy/done 0 immediately;
//     trig held high through release -> one hold starting after release.
//   LED_BLINK_EN, edge at cycle 10 -> led pattern 1,1,0,0,1 on cycles 11..15.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and defaults for the LED pulse stretcher.
// Optional blink mode is enabled by defining LED_BLINK_EN.
package led_pkg;

  localparam int DEF_HOLD_CYCLES = 500;
  localparam int DEF_GAP_CYCLES  = 0;
  localparam int DEF_BLINK_HALF  = 25;

  typedef logic [1:0] state_t;

  typedef enum state_t {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } led_state_e;

  // Terminal count for an N-cycle interval; a zero-length interval clamps to 0.
  function automatic int lastIndex(input int n);
    return (n > 0) ? n - 1 : 0;
  endfunction

endpackage

// File: rtl/led_oneshot_ch.sv
// One LED channel: trigger edge detect, IDLE/ON/GAP one-shot FSM and hold counter.
// With LED_BLINK_EN defined the LED toggles every BLINK_HALF cycles while ON.
module led_oneshot_ch
  import led_pkg::*;
#(
  parameter int CNT_W       = 11,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int RETRIG      = 1
`ifdef LED_BLINK_EN
  ,
  parameter int BLINK_HALF  = DEF_BLINK_HALF
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic trig_i,
  output logic led_o,
  output logic busy_o,
  output logic done_o
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(lastIndex(HOLD_CYCLES));
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(lastIndex(GAP_CYCLES));
  localparam logic             HOLD_ONE  = (HOLD_CYCLES == 1);
  localparam logic             RETRIG_EN = (RETRIG != 0);
  localparam logic             HAS_GAP   = (GAP_CYCLES > 0);
`ifdef LED_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(lastIndex(BLINK_HALF));
`endif

  led_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             trig_q;
  logic             led_q;
  logic             busy_q;
  logic             done_q;
`ifdef LED_BLINK_EN
  logic [CNT_W-1:0] blinkCnt_q;
`endif

  logic             trigEdge;
  logic [CNT_W-1:0] cntInc;

  assign trigEdge = trig_i & ~trig_q;
  assign cntInc   = cnt_q + 1'b1;

  // done is raised on the last lit cycle, so it is loaded one cycle ahead
  // from the value the counter is about to take.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      trig_q     <= 1'b0;
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef LED_BLINK_EN
      blinkCnt_q <= '0;
`endif
    end else begin
      trig_q <= trig_i;
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          led_q  <= 1'b0;
          if (trigEdge) begin
            state_q    <= ST_ON;
            cnt_q      <= '0;
            led_q      <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= HOLD_ONE;
`ifdef LED_BLINK_EN
            blinkCnt_q <= '0;
`endif
          end
        end
        ST_ON: begin
          if (trigEdge && RETRIG_EN) begin
            cnt_q      <= '0;
            led_q      <= 1'b1;
            done_q     <= HOLD_ONE;
`ifdef LED_BLINK_EN
            blinkCnt_q <= '0;
`endif
          end else if (cnt_q == HOLD_LAST) begin
            cnt_q  <= '0;
            led_q  <= 1'b0;
            done_q <= 1'b0;
            if (HAS_GAP) begin
              state_q <= ST_GAP;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q  <= cntInc;
            done_q <= (cntInc == HOLD_LAST);
`ifdef LED_BLINK_EN
            if (blinkCnt_q == BLINK_LAST) begin
              blinkCnt_q <= '0;
              led_q      <= ~led_q;
            end else begin
              blinkCnt_q <= blinkCnt_q + 1'b1;
            end
`endif
          end
        end
        ST_GAP: begin
          done_q <= 1'b0;
          led_q  <= 1'b0;
          if (cnt_q == GAP_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cntInc;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          led_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign led_o  = led_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/led_pulse_stretcher.sv
// Multi-channel LED one-shot driver: NUM_CH independent led_oneshot_ch instances.
// Define LED_BLINK_EN to make lit LEDs blink with half-period BLINK_HALF.
module led_pulse_stretcher
  import led_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 11,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int RETRIG      = 1,
  parameter int BLINK_HALF  = DEF_BLINK_HALF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] trig,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);

  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    led_oneshot_ch #(
      .CNT_W       (CNT_W),
      .HOLD_CYCLES (HOLD_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES),
      .RETRIG      (RETRIG)
`ifdef LED_BLINK_EN
      ,
      .BLINK_HALF  (BLINK_HALF)
`endif
    ) uCh (
      .clk_i  (clk),
      .rst_i  (rst),
      .trig_i (trig[g]),
      .led_o  (led[g]),
      .busy_o (busy[g]),
      .done_o (done[g])
    );
  end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Testbench for led_pulse_stretcher: example scenarios, reset corner and random traffic.
// Two DUTs share the triggers: one with retrigger enabled, one with it disabled.
module tb_led_pulse_stretcher;

  localparam int HOLD = 5;
  localparam int GAP  = 3;
  localparam int HALF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] trig = 4'b0;
  logic [3:0] ledR, busyR, doneR;
  logic [3:0] ledN, busyN, doneN;

  always #5 clk = ~clk;

  led_pulse_stretcher #(
    .NUM_CH(4), .CNT_W(11), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .RETRIG(1), .BLINK_HALF(HALF)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig), .led(ledR), .busy(busyR), .done(doneR)
  );

  led_pulse_stretcher #(
    .NUM_CH(4), .CNT_W(11), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .RETRIG(0), .BLINK_HALF(HALF)
  ) dutNr (
    .clk(clk), .rst(rst), .trig(trig), .led(ledN), .busy(busyN), .done(doneN)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Reference model: per DUT and channel, the current lit window, and busy window.
  int         mStart    [2][4];
  int         mEnd      [2][4];
  int         mGapEnd   [2][4];
  int         mBusyFrom [2][4];
  logic [3:0] mPrev;

  typedef struct {
    string name;
    bit    useNr;
    int    e0, e1, e2;
    int    s0, f0, s1, f1;
    int    d0, d1;
    int    bs0, be0, bs1, be1;
  } scen_t;

  scen_t tbl [4];

  function automatic logic blinkLevel(input int c, input int s);
`ifdef LED_BLINK_EN
    return (((c - s) / HALF) % 2) == 0;
`else
    return c >= s;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < 4; ch++) begin
        mStart[d][ch]    = -100;
        mEnd[d][ch]      = -100;
        mGapEnd[d][ch]   = -100;
        mBusyFrom[d][ch] = -100;
      end
    end
    mPrev = 4'b0;
  endtask

  task automatic modelEvent(input logic [3:0] t, input int c);
    for (int ch = 0; ch < 4; ch++) begin
      if (t[ch] && !mPrev[ch]) begin
        for (int d = 0; d < 2; d++) begin
          if (c > mGapEnd[d][ch]) begin
            mBusyFrom[d][ch] = c + 1;
            mStart[d][ch]    = c + 1;
            mEnd[d][ch]      = c + HOLD;
            mGapEnd[d][ch]   = c + HOLD + GAP;
          end else if (d == 0 && c >= mStart[d][ch] && c <= mEnd[d][ch]) begin
            mStart[d][ch]  = c + 1;
            mEnd[d][ch]    = c + HOLD;
            mGapEnd[d][ch] = c + HOLD + GAP;
          end
        end
      end
    end
    mPrev = t;
  endtask

  task automatic checkModel();
    logic [3:0] el, eb, ed;
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < 4; ch++) begin
        el[ch] = (cyc >= mStart[d][ch]) && (cyc <= mEnd[d][ch]) && blinkLevel(cyc, mStart[d][ch]);
        eb[ch] = (cyc >= mBusyFrom[d][ch]) && (cyc <= mGapEnd[d][ch]);
        ed[ch] = (cyc == mEnd[d][ch]);
      end
      if (d == 0) begin
        checkOutput("modelLedR", ledR, el);
        checkOutput("modelBusyR", busyR, eb);
        checkOutput("modelDoneR", doneR, ed);
      end else begin
        checkOutput("modelLedN", ledN, el);
        checkOutput("modelBusyN", busyN, eb);
        checkOutput("modelDoneN", doneN, ed);
      end
    end
  endtask

  // Called at a falling edge: drive this cycle's trigger, then move to the next cycle.
  task automatic applyStimulus(input logic [3:0] t);
    trig = t;
    modelEvent(t, cyc);
    @(negedge clk);
    cyc++;
  endtask

  task automatic resetDut();
    rst  = 1'b1;
    trig = 4'b0;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic runScenario(input scen_t s);
    logic [3:0] actL, actB, actD;
    logic       eL, eB, eD, t0;
    resetDut();
    for (int c = 0; c < 35; c++) begin
      eL = ((cyc >= s.s0 && cyc <= s.f0) && blinkLevel(cyc, s.s0)) ||
           ((cyc >= s.s1 && cyc <= s.f1) && blinkLevel(cyc, s.s1));
      eB = (cyc >= s.bs0 && cyc <= s.be0) || (cyc >= s.bs1 && cyc <= s.be1);
      eD = (cyc == s.d0) || (cyc == s.d1);
      actL = s.useNr ? ledN  : ledR;
      actB = s.useNr ? busyN : busyR;
      actD = s.useNr ? doneN : doneR;
      checkOutput({s.name, "Led"},  actL, {3'b0, eL});
      checkOutput({s.name, "Busy"}, actB, {3'b0, eB});
      checkOutput({s.name, "Done"}, actD, {3'b0, eD});
      t0 = (cyc == s.e0) || (cyc == s.e1) || (cyc == s.e2);
      applyStimulus({3'b0, t0});
    end
  endtask

  initial begin
    tbl[0] = '{"single",  1'b0, 10, -1, -1, 11, 15, -1, -2, 15, -1, 11, 18, -1, -2};
    tbl[1] = '{"retrig",  1'b0, 10, 13, -1, 11, 13, 14, 18, 18, -1, 11, 21, -1, -2};
    tbl[2] = '{"noRetrig",1'b1, 10, 13, -1, 11, 15, -1, -2, 15, -1, 11, 18, -1, -2};
    tbl[3] = '{"gapEdge", 1'b0, 10, 17, 20, 11, 15, 21, 25, 15, 25, 11, 18, 21, 28};

    for (int i = 0; i < 4; i++) runScenario(tbl[i]);

    // Reset asserted while lit, with the trigger held high through release.
    resetDut();
    while (cyc < 13) begin
      checkModel();
      applyStimulus((cyc >= 10) ? 4'b0001 : 4'b0000);
    end
    checkOutput("preRstLed", {3'b0, ledR[0]}, {3'b0, blinkLevel(13, 11)});
    checkOutput("preRstBusy", busyR, 4'b0001);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstLed",  ledR,  4'b0);
    checkOutput("rstBusy", busyR, 4'b0);
    checkOutput("rstDone", doneR, 4'b0);
    checkOutput("rstBusyN", busyN, 4'b0);
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int c = 0; c < 12; c++) begin
      checkModel();
      if (cyc == 0) checkOutput("relIdle", ledR, 4'b0);
      if (cyc == 1) checkOutput("relLedOn", {3'b0, ledR[0]}, 4'b0001);
      if (cyc == 5) checkOutput("relDone", doneR, 4'b0001);
      if (cyc == 6) checkOutput("relLedOff", ledR, 4'b0);
      if (cyc == 8) checkOutput("relGapBusy", busyR, 4'b0001);
      if (cyc == 9) checkOutput("relIdleAgain", busyR, 4'b0);
      applyStimulus(4'b0001);
    end

    // Random multi-channel traffic against the reference model.
    resetDut();
    for (int c = 0; c < 600; c++) begin
      logic [3:0] t;
      t = trig;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) t[i] = ~t[i];
      end
      checkModel();
      applyStimulus(t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
